// File: rtl/collision_event_arbiter_if.sv
// Collision/event bus between the pixel collision detector, the arbiter and game logic.
// slave: arbiter side (takes collisions, drives events). master: the opposite side.
interface collision_event_arbiter_if #(
  parameter int SCORE_W = 16
);
  logic               startOfFrame;
  logic               col_player_hugeBall, col_rope_hugeBall;
  logic               col_player_bigBall1, col_rope_bigBall1;
  logic               col_player_bigBall2, col_rope_bigBall2;
  logic               hugeBallAlive, bigBall1Alive, bigBall2Alive;
  logic               split_hugeBall, pop_bigBall1, pop_bigBall2;
  logic               rope_retract, player_hit;
  logic [2:0]         lives;
  logic [SCORE_W-1:0] score;
  logic               invulnerable, game_over;

  modport slave (
    input  startOfFrame,
    input  col_player_hugeBall, col_rope_hugeBall,
    input  col_player_bigBall1, col_rope_bigBall1,
    input  col_player_bigBall2, col_rope_bigBall2,
    input  hugeBallAlive, bigBall1Alive, bigBall2Alive,
    output split_hugeBall, pop_bigBall1, pop_bigBall2,
    output rope_retract, player_hit, lives, score, invulnerable, game_over
  );

  modport master (
    output startOfFrame,
    output col_player_hugeBall, col_rope_hugeBall,
    output col_player_bigBall1, col_rope_bigBall1,
    output col_player_bigBall2, col_rope_bigBall2,
    output hugeBallAlive, bigBall1Alive, bigBall2Alive,
    input  split_hugeBall, pop_bigBall1, pop_bigBall2,
    input  rope_retract, player_hit, lives, score, invulnerable, game_over
  );
endinterface

// File: rtl/collision_event_arbiter.sv
// Per-frame collision event arbiter: sticky collision capture during the raster,
// one evaluation per startOfFrame producing single-cycle game events, plus
// lives/score/invulnerability/game-over bookkeeping.
module collision_event_arbiter #(
  parameter int LIVES_INIT    = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int SCORE_HUGE    = 10,
  parameter int SCORE_BIG     = 20,
  parameter int SCORE_W       = 16
) (
  input  logic                      clk,
  input  logic                      resetN,
  collision_event_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {PLAY = 2'd0, INVULN = 2'd1, OVER = 2'd2} state_t;

  state_t             state, nextState;
  // Bit order everywhere: {huge, bigBall1, bigBall2}
  logic [2:0]         ropeCol, playerCol, aliveV;
  logic [2:0]         ropeFlags, playerFlags, ropeWin;
  logic               hitNow;
  logic [7:0]         invCnt;
  logic [2:0]         lives;
  logic [SCORE_W-1:0] score, scoreAdd;
  logic [SCORE_W:0]   scoreSum;
  logic               splitR, pop1R, pop2R, retractR, hitR;

  assign ropeCol   = {bus.col_rope_hugeBall, bus.col_rope_bigBall1, bus.col_rope_bigBall2};
  assign playerCol = {bus.col_player_hugeBall, bus.col_player_bigBall1, bus.col_player_bigBall2};
  assign aliveV    = {bus.hugeBallAlive, bus.bigBall1Alive, bus.bigBall2Alive};

  // Sticky capture; a collision in the startOfFrame cycle belongs to no frame
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ropeFlags   <= '0;
      playerFlags <= '0;
    end else if (bus.startOfFrame || state == OVER) begin
      ropeFlags   <= '0;
      playerFlags <= '0;
    end else begin
      ropeFlags   <= ropeFlags | (ropeCol & aliveV);
      playerFlags <= playerFlags | (playerCol & aliveV);
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= PLAY;
    else         state <= nextState;
  end

  // Next state; player hits only count in PLAY, invulnerability ends on the invCnt==1 frame
  always_comb begin
    nextState = state;
    hitNow    = 1'b0;
    if (bus.startOfFrame) begin
      case (state)
        PLAY: if (|playerFlags) begin
          hitNow    = 1'b1;
          nextState = (lives == 3'd1) ? OVER : INVULN;
        end
        INVULN: if (invCnt == 8'd1) nextState = PLAY;
        default: nextState = state;
      endcase
    end
  end

  // Rope arbitration: one-hot winner, huge > bigBall1 > bigBall2, losers dropped
  always_comb begin
    ropeWin = '0;
    if (bus.startOfFrame && state != OVER) begin
      if (ropeFlags[2])      ropeWin = 3'b100;
      else if (ropeFlags[1]) ropeWin = 3'b010;
      else if (ropeFlags[0]) ropeWin = 3'b001;
    end
  end

  // Score increment with one extra bit to detect saturation
  always_comb begin
    scoreAdd = '0;
    if (ropeWin[2])          scoreAdd = SCORE_W'(SCORE_HUGE);
    else if (|ropeWin[1:0])  scoreAdd = SCORE_W'(SCORE_BIG);
    scoreSum = {1'b0, score} + {1'b0, scoreAdd};
  end

  // Registered event pulses and counters, all one cycle after startOfFrame
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      splitR   <= 1'b0;
      pop1R    <= 1'b0;
      pop2R    <= 1'b0;
      retractR <= 1'b0;
      hitR     <= 1'b0;
      lives    <= 3'(LIVES_INIT);
      score    <= '0;
      invCnt   <= '0;
    end else begin
      splitR   <= ropeWin[2];
      pop1R    <= ropeWin[1];
      pop2R    <= ropeWin[0];
      retractR <= |ropeWin;
      hitR     <= hitNow;
      if (hitNow) lives <= lives - 3'd1;
      score    <= scoreSum[SCORE_W] ? '1 : scoreSum[SCORE_W-1:0];
      if (hitNow && nextState == INVULN)            invCnt <= 8'(INVULN_FRAMES);
      else if (bus.startOfFrame && state == INVULN) invCnt <= invCnt - 8'd1;
    end
  end

  // Output decode
  always_comb begin
    bus.split_hugeBall = splitR;
    bus.pop_bigBall1   = pop1R;
    bus.pop_bigBall2   = pop2R;
    bus.rope_retract   = retractR;
    bus.player_hit     = hitR;
    bus.lives          = lives;
    bus.score          = score;
    bus.invulnerable   = (state == INVULN);
    bus.game_over      = (state == OVER);
  end

endmodule

// File: doc/collision_event_arbiter.md
# collision_event_arbiter

Per-frame collision event arbiter sitting directly downstream of the pixel-level collision detector. Raw collision signals pulse on every overlapping pixel during the raster scan. This block captures them into sticky per-frame flags. At each frame boundary it converts them into single-cycle game events: ball split/pop, rope retract, player hit. It also owns the lives counter, score, post-hit invulnerability window and game-over state.

## Interface
Parameters:
- LIVES_INIT, 3: lives after reset (1..7)
- INVULN_FRAMES, 60: frames of invulnerability after a player hit (1..255)
- SCORE_HUGE, 10: points for a rope hit on the huge ball
- SCORE_BIG, 20: points for a rope hit on a big ball
- SCORE_W, 16: score width

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse marking frame boundary
- col_player_hugeBall, col_rope_hugeBall  in  1 each  raw pixel collisions
- col_player_bigBall1, col_rope_bigBall1  in  1 each  raw pixel collisions
- col_player_bigBall2, col_rope_bigBall2  in  1 each  raw pixel collisions
- hugeBallAlive, bigBall1Alive, bigBall2Alive  in  1 each  ball currently active; collisions with dead balls ignored
- split_hugeBall  out  1  one-cycle pulse: huge ball splits into big balls
- pop_bigBall1, pop_bigBall2  out  1 each  one-cycle pulse: big ball destroyed
- rope_retract  out  1  one-cycle pulse: rope consumed by a hit
- player_hit  out  1  one-cycle pulse: life lost
- lives  out  3  remaining lives
- score  out  SCORE_W  accumulated score
- invulnerable  out  1  high during invulnerability window
- game_over  out  1  sticky, high when lives reach 0

## Operation
- Six sticky flags, one per collision input. A flag sets when its input AND the matching Alive bit are high on a cycle where startOfFrame is low.
- On startOfFrame, all flags are evaluated as captured, then cleared. A collision arriving in the same cycle as startOfFrame is discarded and does not belong to either frame.
- Rope arbitration: at most one rope event per frame. Priority is huge > bigBall1 > bigBall2.
  - The winning event pulses its output (split_hugeBall / pop_bigBall1 / pop_bigBall2) together with rope_retract.
  - Score adds SCORE_HUGE or SCORE_BIG, saturating at 2^SCORE_W-1.
  - Losing rope flags are dropped.
- Player logic, FSM states PLAY, INVULN, OVER:
  - PLAY: any player flag set at evaluation causes player_hit to pulse and lives to decrement. If the new lives value is 0, go to OVER. Otherwise load invCnt=INVULN_FRAMES and go to INVULN.
  - INVULN: player flags are ignored. invCnt decrements at each startOfFrame. At the evaluation where invCnt==1, return to PLAY; player flags of that frame are still ignored. invulnerable=1 in this state.
  - OVER: game_over=1. All event outputs are held 0 and flags are held clear. Only reset exits this state.
- A rope event and a player hit in the same frame are both processed. This includes the player hit that enters OVER: the rope event and score of that frame still count.

## Timing
- Event pulses, and the lives, score and state updates, take effect on the cycle after startOfFrame (latency 1). Each pulse is exactly 1 cycle wide.
- Reset values:
  - split_hugeBall, pop_bigBall1, pop_bigBall2, rope_retract, player_hit = 0
  - lives = LIVES_INIT, score = 0
  - invulnerable = 0, game_over = 0
  - state = PLAY, all flags cleared, invCnt = 0
- Reset asserted mid-frame discards the captured flags immediately. No event fires for the interrupted frame.
- Back-to-back startOfFrame pulses on consecutive cycles are legal. The second evaluates an empty flag set, apart from decrementing invCnt.
- An Alive bit dropping mid-frame does not clear a flag that is already set.

## Test plan
- Rope/huge hit: col_rope_hugeBall=1 for 5 cycles with hugeBallAlive=1, then startOfFrame -> next cycle split_hugeBall=1 and rope_retract=1 for 1 cycle; score 0→10.
- Rope priority: rope hits on bigBall1 and bigBall2 in the same frame -> only pop_bigBall1 pulses; score +20; bigBall2 flag dropped; next frame with no hits produces no pulses.
- Invulnerability: player hit in frame N -> player_hit pulses, lives 3→2, invulnerable=1. Player hits in frames N+1..N+60 are ignored; invulnerable falls after the 60th boundary. A hit in frame N+61 makes lives 1.
- Game over: with lives=1 in PLAY, player hit plus rope hit on bigBall2 in the same frame -> pop_bigBall2 pulses, score +20, lives=0, game_over=1. Later collisions produce no pulses.
- Boundary and gating: a collision only in the startOfFrame cycle -> no event. col_rope_hugeBall with hugeBallAlive=0 -> no event. resetN low mid-frame after hits -> outputs return to reset values and no pulse follows.
